// File: rtl/edge_counter_pkg.sv
// Shared types and elaboration limits for the edge window counter.
package edge_counter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    localparam int unsigned WINDOW_MIN = 2;
    localparam int unsigned SYNC_MIN   = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous pulse train and emits a one-cycle strobe per rising edge.
module edge_sync
    import edge_counter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pulse,
    output logic rise
);

    if (SYNC_STAGES < SYNC_MIN) begin : gen_sync_check
        $error("edge_sync: SYNC_STAGES below minimum");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/edge_window_counter.sv
// Counts synchronized rising edges over fixed windows and hands each window's count
// downstream through a one-deep valid/ready register, dropping windows it cannot deliver.
module edge_window_counter
    import edge_counter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned WINDOW_CYCLES = 256,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Edge,
    input  logic                   Enable,
    output logic [COUNT_WIDTH-1:0] CountData,
    output logic                   CountOverflow,
    output logic                   CountValid,
    input  logic                   CountReady,
    output logic                   DroppedWindow
);

    if (WINDOW_CYCLES < WINDOW_MIN) begin : gen_window_check
        $error("edge_window_counter: WINDOW_CYCLES below minimum");
    end

    localparam int unsigned TIMER_WIDTH = $clog2(WINDOW_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_LOAD = TIMER_WIDTH'(WINDOW_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;

    state_e                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [COUNT_WIDTH-1:0] acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [COUNT_WIDTH-1:0] data_q, data_d;
    logic                   data_ovf_q, data_ovf_d;
    logic                   valid_q, valid_d;
    logic                   drop_q, drop_d;

    logic                   rise;
    logic                   acc_full;
    logic [COUNT_WIDTH-1:0] acc_next;
    logic                   ovf_next;
    logic                   terminal;
    logic                   load;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock (Clock),
        .reset (Reset),
        .pulse (Edge),
        .rise  (rise)
    );

    // Accumulator value including this cycle's event, so a terminal-cycle event still counts.
    always_comb begin
        acc_full = (acc_q == COUNT_MAX);
        acc_next = (rise && !acc_full) ? acc_q + 1'b1 : acc_q;
        ovf_next = ovf_q | (rise & acc_full);
        terminal = (state_q == StRun) && (timer_q == '0);
        load     = terminal && (!valid_q || CountReady);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (Enable) begin
                    state_d = StRun;
                    timer_d = TIMER_LOAD;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            StRun: begin
                if (terminal) begin
                    timer_d = TIMER_LOAD;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    acc_d   = acc_next;
                    ovf_d   = ovf_next;
                end
                // A closing window still delivers; only the next one is abandoned.
                if (!Enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        data_ovf_d = data_ovf_q;
        valid_d    = valid_q & ~CountReady;
        drop_d     = 1'b0;
        if (terminal) begin
            if (load) begin
                data_d     = acc_next;
                data_ovf_d = ovf_next;
                valid_d    = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            data_q     <= '0;
            data_ovf_q <= 1'b0;
            valid_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
            data_ovf_q <= data_ovf_d;
            valid_q    <= valid_d;
            drop_q     <= drop_d;
        end
    end

    assign CountData     = data_q;
    assign CountOverflow = data_ovf_q;
    assign CountValid    = valid_q;
    assign DroppedWindow = drop_q;

endmodule
